buf_uart_tx: RTL

- Downstream consumer of `buf_ram`.
- On a `start` pulse it walks the 512×8 text buffer from address 0 and serializes each byte onto a UART line as 8N1.
- One byte is read per frame, through the buffer's synchronous read port.
- It is the stage that turns the buffered text into the board's serial console output.

---
 rtl/buf_pkg.sv | 28 ++
 rtl/baud_gen.sv | 35 +++
 rtl/buf_uart_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/buf_pkg.sv
// Shared definitions for the text-buffer pipeline (buf_ram, buf_uart_tx and
// later buffer stages).
//   BUF_ADDR_W / BUF_DATA_W / BUF_DEPTH : geometry of the 512x8 text buffer
//   BUF_LEN_W                           : width of a byte count (0..BUF_DEPTH)
//   buf_tx_state_t                      : state encoding of the UART transmitter
//   clamp_len()                         : limits a byte count to the buffer depth
package buf_pkg;

    localparam int BUF_ADDR_W = 9;
    localparam int BUF_DATA_W = 8;
    localparam int BUF_DEPTH  = 512;
    localparam int BUF_LEN_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_FIN
    } buf_tx_state_t;

    function automatic logic [BUF_LEN_W-1:0] clamp_len(input logic [BUF_LEN_W-1:0] l);
        return (l > BUF_LEN_W'(BUF_DEPTH)) ? BUF_LEN_W'(BUF_DEPTH) : l;
    endfunction

endpackage

// File: rtl/baud_gen.sv
// Loadable bit-period down-counter shared by the UART transmitter and the
// planned receiver.
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset (count = 0)
//   load : restart the period; count becomes CLK_DIV-1 on the next cycle
//   tick : high for the one cycle in which the count is 0 (last cycle of a bit)
// The counter reloads itself after reaching 0, so consecutive bits need no
// further load pulses.
module baud_gen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load || cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/buf_uart_tx.sv
// Walks the text buffer from address 0 and sends each byte as an 8N1 UART
// frame; this is the board's serial console output stage.
//   clk, rst   : clock and synchronous active-high reset
//   start, len : transfer request (sampled in IDLE) and byte count (>512 -> 512)
//   busy, done : transfer in progress / one-cycle end-of-transfer pulse
//   ram_addr   : buffer read address; ram_rdata returns one cycle later
//   txd        : serial line, idle high
// Optional build macro BUF_UART_TX_NUL_STOP_EN: a 8'h00 byte ends the transfer
// without being sent.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for start
// FETCH | ram_addr stable while the buffer registers it
// LOAD  | read data captured into shreg, baud counter restarted
// START | start bit (txd=0) for CLK_DIV cycles
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (txd=1); next byte or finish
// FIN   | done pulse, back to IDLE
module buf_uart_tx
    import buf_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BUF_LEN_W-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [BUF_ADDR_W-1:0] ram_addr,
    input  logic [BUF_DATA_W-1:0] ram_rdata,
    output logic                  txd
);

    buf_tx_state_t         state;
    logic [BUF_LEN_W-1:0]  remain;
    logic [BUF_DATA_W-1:0] shreg;
    logic [2:0]            bitcnt;
    logic                  baud_load;
    logic                  tick;

    // Restarting the counter in LOAD makes the start bit exactly CLK_DIV long.
    assign baud_load = (state == ST_LOAD);

    baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .load (baud_load),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            remain   <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            ram_addr <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    txd  <= 1'b1;
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (len != '0) begin
                            remain   <= clamp_len(len);
                            ram_addr <= '0;
                            state    <= ST_FETCH;
                        end else begin
                            state <= ST_FIN;
                        end
                    end
                end

                ST_FETCH: begin
                    state <= ST_LOAD;
                end

                ST_LOAD: begin
`ifdef BUF_UART_TX_NUL_STOP_EN
                    if (ram_rdata == '0) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end else begin
                        shreg  <= ram_rdata;
                        bitcnt <= '0;
                        txd    <= 1'b0;
                        state  <= ST_START;
                    end
`else
                    shreg  <= ram_rdata;
                    bitcnt <= '0;
                    txd    <= 1'b0;
                    state  <= ST_START;
`endif
                end

                ST_START: begin
                    if (tick) begin
                        txd   <= shreg[0];
                        state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        shreg  <= shreg >> 1;
                        bitcnt <= bitcnt + 1'b1;
                        if (bitcnt == 3'd7) begin
                            txd   <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            txd <= shreg[1];
                        end
                    end
                end

                ST_STOP: begin
                    if (tick) begin
                        if (remain != '0) begin
                            remain <= remain - 1'b1;
                        end
                        if (remain <= BUF_LEN_W'(1)) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            ram_addr <= ram_addr + 1'b1;
                            state    <= ST_FETCH;
                        end
                    end
                end

                ST_FIN: begin
                    // A zero-length request arrives here with done still low,
                    // so it spends one extra cycle before pulsing done.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
